// File: rtl/sobel_edge.sv
// sobel_edge: Sobel gradient-magnitude edge detector for a cartoon overlay.
// Takes the 3x3 RGB neighbourhood from the 3-line buffer and converts it to
// luminance. It thresholds |Gx|+|Gy| and emits the window's centre pixel,
// blacked out where an edge is found.
// Latency: exactly 3 clken-high cycles from iGrid sample to registered output.
// Ports:
//   clock, reset        - system clock, synchronous active-high reset
//   clken               - pixel enable shared with the line buffer; all state holds while low
//   iFrameStart         - with clken, marks the first pixel of a frame (col 0, row 0)
//   iGrid[269:0]        - 3x3 window, grid[k] = iGrid[30k+29:30k], {R,G,B} x 10 bits
//   iThreshold[12:0]    - unsigned edge threshold, sampled at the output stage
//   oPixel[29:0]        - output pixel {R,G,B}
//   oEdge               - oPixel is an edge (blacked out)
//   oValid              - oPixel comes from a fully populated window
// Build options:
//   VGA_640x480p60      - default frame geometry 640x480 instead of 800x600
//   CARTOON_QUANT_EN    - posterise non-edge output pixels to 4 bits per channel

module sobel_edge #(
`ifdef VGA_640x480p60
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480
`else
  parameter int WIDTH  = 800,
  parameter int HEIGHT = 600
`endif
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         clken,
  input  logic         iFrameStart,
  input  logic [269:0] iGrid,
  input  logic [12:0]  iThreshold,
  output logic [29:0]  oPixel,
  output logic         oEdge,
  output logic         oValid
);

  localparam int CW = (WIDTH  > 1) ? $clog2(WIDTH)  : 1;
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);

  // Luminance approximation (R + 2G + B) / 4; the 12-bit sum cannot overflow.
  function automatic logic [9:0] gray(input logic [29:0] p);
    logic [11:0] s;
    s = {2'b00, p[29:20]} + {1'b0, p[19:10], 1'b0} + {2'b00, p[9:0]};
    return s[11:2];
  endfunction

  // a + 2b + c as a non-negative 13-bit signed value (max 4092).
  function automatic logic signed [12:0] wsum(input logic [9:0] a, input logic [9:0] b,
                                              input logic [9:0] c);
    return $signed({3'b000, a}) + $signed({2'b00, b, 1'b0}) + $signed({3'b000, c});
  endfunction

`ifdef CARTOON_QUANT_EN
  // Keep the top 4 bits of each channel and park the rest at the bin midpoint.
  function automatic logic [29:0] shade(input logic [29:0] p);
    return {p[29:26], 6'b100000, p[19:16], 6'b100000, p[9:6], 6'b100000};
  endfunction
`else
  function automatic logic [29:0] shade(input logic [29:0] p);
    return p;
  endfunction
`endif

  // ---------------------------------------------------------------------------
  // Raster position of the current sample
  // ---------------------------------------------------------------------------
  logic [CW-1:0] col_q, col_d, cur_col;
  logic [RW-1:0] row_q, row_d, cur_row;
  logic          win_vld;

  always_comb begin
    // A frame start relabels this very sample as (0,0), so it also beats any wrap.
    cur_col = iFrameStart ? '0 : col_q;
    cur_row = iFrameStart ? '0 : row_q;
    col_d   = cur_col + CW'(1);
    row_d   = cur_row;
    if (cur_col == COL_LAST) begin
      col_d = '0;
      row_d = (cur_row == ROW_LAST) ? '0 : cur_row + RW'(1);
    end
    win_vld = (cur_row >= RW'(2)) && (cur_col >= CW'(2));
  end

  // ---------------------------------------------------------------------------
  // Stage 1: luminance of the eight neighbours, centre RGB, window valid.
  // The centre's own luminance carries no Sobel weight, so it is not kept.
  // Neighbour slot j holds grid index j for j<4 and grid index j+1 otherwise.
  // ---------------------------------------------------------------------------
  logic [9:0]  g_q [8];
  logic [9:0]  g_d [8];
  logic [29:0] ctr1_q;
  logic        vld1_q;

  always_comb begin
    for (int j = 0; j < 8; j++) begin
      g_d[j] = gray(iGrid[30*((j < 4) ? j : j + 1) +: 30]);
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: signed gradients. Right column (0,3,6) minus left column (2,5,8);
  // top rows (6,7,8, newest) minus bottom rows (0,1,2, oldest).
  // ---------------------------------------------------------------------------
  logic signed [12:0] gx_q, gx_d, gy_q, gy_d;
  logic [29:0]        ctr2_q;
  logic               vld2_q;

  // Slots: g0=0 g1=1 g2=2 g3=3 g5=4 g6=5 g7=6 g8=7
  always_comb begin
    gx_d = wsum(g_q[5], g_q[3], g_q[0]) - wsum(g_q[7], g_q[4], g_q[2]);
    gy_d = wsum(g_q[5], g_q[6], g_q[7]) - wsum(g_q[0], g_q[1], g_q[2]);
  end

  // ---------------------------------------------------------------------------
  // Stage 3: magnitude, threshold, output pixel selection
  // ---------------------------------------------------------------------------
  logic [12:0] ax, ay, mag;
  logic        edge_d;
  logic [29:0] pix_d;
  logic [29:0] pix_q;
  logic        edge_q, vld_q;

  always_comb begin
    // |G| <= 4092 so negation never overflows, and the sum stays <= 8184.
    ax     = gx_q[12] ? 13'(-gx_q) : 13'(gx_q);
    ay     = gy_q[12] ? 13'(-gy_q) : 13'(gy_q);
    mag    = ax + ay;
    edge_d = vld2_q && (mag > iThreshold);
    pix_d  = edge_d ? 30'd0 : shade(ctr2_q);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      col_q  <= '0;
      row_q  <= '0;
      for (int j = 0; j < 8; j++) g_q[j] <= '0;
      ctr1_q <= '0;
      vld1_q <= 1'b0;
      gx_q   <= '0;
      gy_q   <= '0;
      ctr2_q <= '0;
      vld2_q <= 1'b0;
      pix_q  <= '0;
      edge_q <= 1'b0;
      vld_q  <= 1'b0;
    end else if (clken) begin
      col_q  <= col_d;
      row_q  <= row_d;
      for (int j = 0; j < 8; j++) g_q[j] <= g_d[j];
      ctr1_q <= iGrid[120 +: 30];
      vld1_q <= win_vld;
      gx_q   <= gx_d;
      gy_q   <= gy_d;
      ctr2_q <= ctr1_q;
      vld2_q <= vld1_q;
      pix_q  <= pix_d;
      edge_q <= edge_d;
      vld_q  <= vld2_q;
    end
  end

  assign oPixel = pix_q;
  assign oEdge  = edge_q;
  assign oValid = vld_q;

endmodule

// File: tb/tb_sobel_edge.sv
// Directed bench for sobel_edge (default 800x600 geometry).
module tb_sobel_edge;

  logic         clock = 1'b0;
  logic         reset;
  logic         clken;
  logic         iFrameStart;
  logic [269:0] iGrid;
  logic [12:0]  iThreshold;
  logic [29:0]  oPixel;
  logic         oEdge;
  logic         oValid;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  sobel_edge dut (
    .clock      (clock),
    .reset      (reset),
    .clken      (clken),
    .iFrameStart(iFrameStart),
    .iGrid      (iGrid),
    .iThreshold (iThreshold),
    .oPixel     (oPixel),
    .oEdge      (oEdge),
    .oValid     (oValid)
  );

  localparam logic [29:0] WHITE = 30'h3FFFFFFF;

  // Expected look of a non-edge pixel
  function automatic logic [29:0] post(input logic [29:0] p);
`ifdef CARTOON_QUANT_EN
    return {p[29:26], 6'h20, p[19:16], 6'h20, p[9:6], 6'h20};
`else
    return p;
`endif
  endfunction

  // Window: positions in msk take alt, the rest take base; grid[4] is ctr.
  function automatic logic [269:0] win(input logic [29:0] base, input logic [29:0] alt,
                                       input logic [8:0] msk, input logic [29:0] ctr);
    logic [269:0] g;
    for (int k = 0; k < 9; k++) g[30*k +: 30] = msk[k] ? alt : base;
    g[120 +: 30] = ctr;
    return g;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clock);
    #1;
  endtask

  // Strong vertical-edge window held through a frame start (optional) and
  // the first 3 rows; checks the invalid border and the first valid outputs.
  task automatic border(input bit use_fs, input string tag);
    bit bad;
    bad        = 1'b0;
    iGrid      = win(WHITE, 30'd0, 9'b100100100, WHITE);
    iThreshold = 13'd100;
    clken      = 1'b1;
    for (int t = 1; t <= 2405; t++) begin
      iFrameStart = use_fs && (t == 1);
      step;
      // steps 1..2 still show samples from before this frame
      if (t >= 3 && t <= 1604 &&
          (oValid !== 1'b0 || oEdge !== 1'b0 || oPixel !== post(WHITE))) bad = 1'b1;
      if (t == 1605) begin
        chk({tag, "_first_valid"}, {31'd0, oValid}, 32'd1);
        chk({tag, "_first_edge"}, {31'd0, oEdge}, 32'd1);
        chk({tag, "_first_pix"}, {2'd0, oPixel}, 32'd0);
      end
      if (t == 2403 || t == 2404) begin
        chk({tag, "_row3_lcol_valid"}, {31'd0, oValid}, 32'd0);
        chk({tag, "_row3_lcol_edge"}, {31'd0, oEdge}, 32'd0);
      end
      if (t == 2405) chk({tag, "_row3_col2_edge"}, {31'd0, oEdge}, 32'd1);
    end
    iFrameStart = 1'b0;
    chk({tag, "_rows01_invalid"}, {31'd0, bad}, 32'd0);
  endtask

  typedef struct {
    string        name;
    logic [269:0] grid;
    logic [12:0]  thr;
    logic [29:0]  ctr;
    logic         edg;
  } vec_t;

  vec_t vt[12];
  bit   gap_cl[6];
  bit   gap_ex[6];

  initial begin
    vt[0]  = '{"flat",        win(WHITE, WHITE, 9'b0, WHITE),           13'd100,  WHITE, 1'b0};
    vt[1]  = '{"vert",        win(WHITE, 30'd0, 9'b100100100, WHITE),   13'd100,  WHITE, 1'b1};
    vt[2]  = '{"vert_mirror", win(WHITE, 30'd0, 9'b001001001, WHITE),   13'd100,  WHITE, 1'b1};
    vt[3]  = '{"thr_4092",    win(WHITE, 30'd0, 9'b100100100, WHITE),   13'd4092, WHITE, 1'b0};
    vt[4]  = '{"thr_4091",    win(WHITE, 30'd0, 9'b100100100, WHITE),   13'd4091, WHITE, 1'b1};
    vt[5]  = '{"horiz",       win(WHITE, 30'd0, 9'b000000111, WHITE),   13'd100,  WHITE, 1'b1};
    vt[6]  = '{"horiz_mir",   win(WHITE, 30'd0, 9'b111000000, WHITE),   13'd4092, WHITE, 1'b0};
    vt[7]  = '{"corner_2045", win(WHITE, 30'd0, 9'b100000000, WHITE),   13'd2045, WHITE, 1'b1};
    vt[8]  = '{"corner_2046", win(WHITE, 30'd0, 9'b100000000, WHITE),   13'd2046, WHITE, 1'b0};
    vt[9]  = '{"green_2043",  win(30'd0, 30'h000FFC00, 9'b001001001, 30'h3FF), 13'd2043, 30'h3FF, 1'b1};
    vt[10] = '{"green_2044",  win(30'd0, 30'h000FFC00, 9'b001001001, 30'h3FF), 13'd2044, 30'h3FF, 1'b0};
    vt[11] = '{"colour_ctr",  win(WHITE, WHITE, 9'b0, {10'h3FF, 10'h155, 10'h000}), 13'd100,
               {10'h3FF, 10'h155, 10'h000}, 1'b0};

    gap_cl = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
    gap_ex = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset with clken low still clears everything
    reset = 1'b1; clken = 1'b0; iFrameStart = 1'b0; iGrid = '0; iThreshold = '0;
    step; step;
    chk("reset_pix", {2'd0, oPixel}, 32'd0);
    chk("reset_edge", {31'd0, oEdge}, 32'd0);
    chk("reset_valid", {31'd0, oValid}, 32'd0);
    reset = 1'b0;

    border(1'b1, "fs_col0");

    // Table: each vector held for 3 clken cycles, mid-row 3 so windows are valid
    for (int i = 0; i < 12; i++) begin
      iGrid = vt[i].grid; iThreshold = vt[i].thr; clken = 1'b1;
      repeat (3) step;
      chk({vt[i].name, "_pix"}, {2'd0, oPixel}, {2'd0, vt[i].edg ? 30'd0 : post(vt[i].ctr)});
      chk({vt[i].name, "_edge"}, {31'd0, oEdge}, {31'd0, vt[i].edg});
      chk({vt[i].name, "_valid"}, {31'd0, oValid}, 32'd1);
    end

    // Latency with clken gaps: edge sample, then flat, clken 1,0,0,1,1,0,1
    iGrid = win(WHITE, WHITE, 9'b0, WHITE); iThreshold = 13'd100; clken = 1'b1;
    repeat (3) step;
    iGrid = win(WHITE, 30'd0, 9'b100100100, WHITE);
    step;
    chk("gap_s1_edge", {31'd0, oEdge}, 32'd0);
    iGrid = win(WHITE, WHITE, 9'b0, WHITE);
    for (int i = 0; i < 6; i++) begin
      clken = gap_cl[i];
      step;
      chk($sformatf("gap_s%0d_edge", i + 2), {31'd0, oEdge}, {31'd0, gap_ex[i]});
      chk($sformatf("gap_s%0d_pix", i + 2), {2'd0, oPixel},
          {2'd0, gap_ex[i] ? 30'd0 : post(WHITE)});
    end

    // Move well into the row, then restart the frame there
    clken = 1'b1;
    repeat (250) step;
    border(1'b1, "fs_mid");

    // Mid-frame reset
    iGrid = win(WHITE, WHITE, 9'b0, WHITE); clken = 1'b1;
    repeat (3) step;
    chk("pre_reset_valid", {31'd0, oValid}, 32'd1);
    reset = 1'b1;
    step;
    chk("midreset_pix", {2'd0, oPixel}, 32'd0);
    chk("midreset_edge", {31'd0, oEdge}, 32'd0);
    chk("midreset_valid", {31'd0, oValid}, 32'd0);
    reset = 1'b0;
    border(1'b0, "post_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
